spi_param_master: RTL and testbench

//  System-clock SPI master that configures and reads back the 8-register SPI parameter slave.

---
 rtl/spi_param_master_if.sv | 23 ++
 rtl/spi_param_master.sv | 196 +++++++++++++++++++
 tb/tb_spi_param_master.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_param_master_if.sv
// Host-side request/acknowledge bus of spi_param_master.
// The master modport is the requester side; the slave modport is the SPI master block.
interface spi_param_master_if;
  logic        wr_req;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic        rd_ack;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        busy;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req,
    input  wr_ack, rd_ack, rd_valid, rd_data, busy
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req,
    output wr_ack, rd_ack, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/spi_param_master.sv
// SPI master (CPOL=0, CPHA=0) that writes single registers of the 8-register parameter
// slave or reads all eight back, round-robin arbitrating between the two requesters.
module spi_param_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_param_master_if.slave host,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);
  localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [6:0]    bit_r;
  logic [6:0]    last_bit_r;
  logic [94:0]   tx_r;
  logic [63:0]   cap_r;
  logic [63:0]   rd_data_r;
  logic          is_rd_r;
  logic          last_rd_r;
  logic          sclk_r;
  logic          cs_n_r;
  logic          mosi_r;
  logic          busy_r;
  logic          wr_ack_r;
  logic          rd_ack_r;
  logic          rd_valid_r;

  logic          grant_wr_s;
  logic          grant_rd_s;
  logic          div_end_s;
  logic          gap_end_s;
  logic [95:0]   frame_s;

  // Bytes arrive MSB first starting with regs[0]; the output image keeps regs[i] at byte i.
  function automatic logic [63:0] byte_rev(input logic [63:0] v);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = v[8*(7-i) +: 8];
    end
    return r;
  endfunction

  // Round-robin grant decision and the frame image for whichever side wins.
  always_comb begin
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (host.wr_req && (!host.rd_req || last_rd_r)) begin
      grant_wr_s = 1'b1;
    end else if (host.rd_req) begin
      grant_rd_s = 1'b1;
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
    if (grant_rd_s) begin
      frame_s = {8'h7E, 8'h7E, 8'h88, 8'h00, 64'd0};
    end else begin
      frame_s = {8'h7E, 8'h7E, 5'd0, host.wr_addr, host.wr_data, 64'd0};
    end
    div_end_s = (cnt_r == DIV_LAST);
    gap_end_s = (cnt_r == GAP_LAST);
  end

  // Frame sequencer: every pin and handshake output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_r      <= 7'd0;
      last_bit_r <= 7'd0;
      tx_r       <= 95'd0;
      cap_r      <= 64'd0;
      rd_data_r  <= 64'd0;
      is_rd_r    <= 1'b0;
      last_rd_r  <= 1'b1;
      sclk_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
      busy_r     <= 1'b0;
      wr_ack_r   <= 1'b0;
      rd_ack_r   <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      wr_ack_r   <= 1'b0;
      rd_ack_r   <= 1'b0;
      rd_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= CNT_ZERO;
          if (grant_wr_s || grant_rd_s) begin
            state_r    <= ST_SETUP;
            busy_r     <= 1'b1;
            cs_n_r     <= 1'b0;
            bit_r      <= 7'd0;
            is_rd_r    <= grant_rd_s;
            last_rd_r  <= grant_rd_s;
            wr_ack_r   <= grant_wr_s;
            rd_ack_r   <= grant_rd_s;
            last_bit_r <= grant_rd_s ? 7'd95 : 7'd31;
            mosi_r     <= frame_s[95];
            tx_r       <= frame_s[94:0];
          end
        end
        ST_SETUP: begin
          if (div_end_s) begin
            cnt_r   <= CNT_ZERO;
            sclk_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SHIFT: begin
          if (!div_end_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            cnt_r <= CNT_ZERO;
            if (sclk_r) begin
              sclk_r <= 1'b0;
              mosi_r <= (bit_r == last_bit_r) ? 1'b0 : tx_r[94];
              tx_r   <= {tx_r[93:0], 1'b0};
            end else if (bit_r == last_bit_r) begin
              state_r <= ST_HOLD;
            end else begin
              sclk_r <= 1'b1;
              bit_r  <= bit_r + 7'd1;
              // Rising edge of bit bit_r+1; bits 32..95 carry the register image.
              if (is_rd_r && (bit_r >= 7'd31)) begin
                cap_r <= {cap_r[62:0], miso};
              end
            end
          end
        end
        ST_HOLD: begin
          if (div_end_s) begin
            cnt_r   <= CNT_ZERO;
            cs_n_r  <= 1'b1;
            state_r <= ST_GAP;
            if (is_rd_r) begin
              rd_data_r  <= byte_rev(cap_r);
              rd_valid_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (gap_end_s) begin
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          sclk_r  <= 1'b0;
          cs_n_r  <= 1'b1;
          mosi_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign host.wr_ack   = wr_ack_r;
  assign host.rd_ack   = rd_ack_r;
  assign host.rd_valid = rd_valid_r;
  assign host.rd_data  = rd_data_r;
  assign host.busy     = busy_r;
  assign sclk          = sclk_r;
  assign cs_n          = cs_n_r;
  assign mosi          = mosi_r;
endmodule

// File: tb/tb_spi_param_master.sv
// Bench for spi_param_master: two instances (CLK_DIV=4/CS_GAP=8 and CLK_DIV=2/CS_GAP=1),
// each talking to a behavioural 8-register parameter slave.
module tb_spi_param_master;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       wr_req_v, rd_req_v;
  logic [1:0][2:0]  wr_addr_v;
  logic [1:0][7:0]  wr_data_v;
  logic [1:0]       wr_ack_v, rd_ack_v, rd_valid_v, busy_v;
  logic [1:0]       sclk_v, cs_n_v, mosi_v, miso_v;
  logic [1:0][63:0] rd_data_v;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_d
    localparam int CD = (gi == 0) ? 4 : 2;
    localparam int CG = (gi == 0) ? 8 : 1;

    spi_param_master_if bus ();
    assign bus.wr_req      = wr_req_v[gi];
    assign bus.wr_addr     = wr_addr_v[gi];
    assign bus.wr_data     = wr_data_v[gi];
    assign bus.rd_req      = rd_req_v[gi];
    assign wr_ack_v[gi]    = bus.wr_ack;
    assign rd_ack_v[gi]    = bus.rd_ack;
    assign rd_valid_v[gi]  = bus.rd_valid;
    assign rd_data_v[gi]   = bus.rd_data;
    assign busy_v[gi]      = bus.busy;

    spi_param_master #(.CLK_DIV(CD), .CS_GAP(CG)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .host (bus),
      .sclk (sclk_v[gi]),
      .cs_n (cs_n_v[gi]),
      .mosi (mosi_v[gi]),
      .miso (miso_v[gi])
    );

    // Parameter slave: samples mosi on sclk rise, presents the image from bit 32 on.
    logic [7:0]  regs [8];
    logic [7:0]  rxb  [12];
    logic [7:0]  sh   = 8'h00;
    logic [63:0] img  = 64'd0;
    logic        out_en = 1'b0;
    int          bitc = 0;
    always @(posedge sclk_v[gi] or posedge cs_n_v[gi]) begin
      if (cs_n_v[gi]) begin
        bitc   <= 0;
        out_en <= 1'b0;
      end else begin
        sh <= {sh[6:0], mosi_v[gi]};
        if (bitc[2:0] == 3'd7 && bitc < 96) rxb[bitc / 8] <= {sh[6:0], mosi_v[gi]};
        if (bitc == 31 && rxb[0] == 8'h7E && rxb[1] == 8'h7E) begin
          if (rxb[2] == 8'h88) begin
            out_en <= 1'b1;
            img    <= {regs[0], regs[1], regs[2], regs[3], regs[4], regs[5], regs[6], regs[7]};
          end else if (rxb[2][7:3] == 5'd0) begin
            regs[rxb[2][2:0]] <= {sh[6:0], mosi_v[gi]};
          end
        end
        bitc <= bitc + 1;
      end
    end
    assign miso_v[gi] = (out_en && !cs_n_v[gi] && bitc >= 32 && bitc < 96) ? img[6'(95 - bitc)] : 1'b0;

    // Pin monitor: cs_n low/high lengths, sclk legality, rd_valid pulses.
    int   cs_cnt = 0, cs_len = 0, hi_cnt = 0, hi_len = 0;
    int   sclk_bad = 0, per_bad = 0, last_rise = -1, vcnt = 0;
    logic cs_q = 1'b1, sclk_q = 1'b0;
    always @(posedge clk) begin
      if (!cs_n_v[gi]) cs_cnt <= cs_cnt + 1;
      if (cs_n_v[gi] && !cs_q) begin
        cs_len <= cs_cnt;
        cs_cnt <= 0;
      end
      if (cs_n_v[gi]) hi_cnt <= hi_cnt + 1;
      if (!cs_n_v[gi] && cs_q) begin
        hi_len    <= hi_cnt;
        hi_cnt    <= 0;
        last_rise <= -1;
      end
      if (cs_n_v[gi] && sclk_v[gi]) sclk_bad <= sclk_bad + 1;
      if (sclk_v[gi] && !sclk_q) begin
        if (last_rise >= 0 && (cyc - last_rise) != 2 * CD) per_bad <= per_bad + 1;
        last_rise <= cyc;
      end
      if (rd_valid_v[gi]) vcnt <= vcnt + 1;
      cs_q   <= cs_n_v[gi];
      sclk_q <= sclk_v[gi];
    end
  end

  function automatic int get_cs_len(input int d);
    return (d == 0) ? g_d[0].cs_len : g_d[1].cs_len;
  endfunction
  function automatic int get_hi_len(input int d);
    return (d == 0) ? g_d[0].hi_len : g_d[1].hi_len;
  endfunction
  function automatic int get_vcnt(input int d);
    return (d == 0) ? g_d[0].vcnt : g_d[1].vcnt;
  endfunction
  function automatic logic [7:0] get_reg(input int d, input logic [2:0] a);
    return (d == 0) ? g_d[0].regs[a] : g_d[1].regs[a];
  endfunction
  function automatic logic [31:0] get_rx(input int d);
    if (d == 0) return {g_d[0].rxb[0], g_d[0].rxb[1], g_d[0].rxb[2], g_d[0].rxb[3]};
    else        return {g_d[1].rxb[0], g_d[1].rxb[1], g_d[1].rxb[2], g_d[1].rxb[3]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int d);
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (!busy_v[d]) done = 1'b1;
    end
    chk("busy_drop_timeout", 64'(done), 64'd1);
  endtask

  task automatic do_write(input int d, input logic [2:0] a, input logic [7:0] v);
    bit got = 1'b0;
    @(negedge clk);
    wr_addr_v[d] = a;
    wr_data_v[d] = v;
    wr_req_v[d]  = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (wr_ack_v[d]) got = 1'b1;
    end
    wr_req_v[d] = 1'b0;
    chk("wr_ack_seen", 64'(got), 64'd1);
    @(negedge clk);
    chk("wr_ack_one_cycle", 64'(wr_ack_v[d]), 64'd0);
    wait_idle(d);
  endtask

  task automatic do_read(input int d, output logic [63:0] data, output int nval);
    bit got = 1'b0;
    bit vld = 1'b0;
    int v0;
    v0   = get_vcnt(d);
    data = 64'd0;
    @(negedge clk);
    rd_req_v[d] = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (rd_ack_v[d]) got = 1'b1;
    end
    rd_req_v[d] = 1'b0;
    chk("rd_ack_seen", 64'(got), 64'd1);
    for (int i = 0; i < 3000 && !vld; i++) begin
      @(negedge clk);
      if (rd_valid_v[d]) begin
        vld  = 1'b1;
        data = rd_data_v[d];
      end
    end
    chk("rd_valid_seen", 64'(vld), 64'd1);
    wait_idle(d);
    nval = get_vcnt(d) - v0;
  endtask

  typedef struct {
    int         d;
    logic [2:0] addr;
    logic [7:0] data;
    int         exp_cs;
  } wvec_t;

  wvec_t       wv [17];
  logic [63:0] rdat;
  int          nval;
  bit          gk [4];
  int          gt [4];
  int          ng;
  int          t_a, t_b, v_before;

  initial begin
    wv[0] = '{0, 3'd3, 8'hA5, 264};
    wv[1] = '{0, 3'd0, 8'h00, 264};  wv[2] = '{0, 3'd1, 8'h11, 264};
    wv[3] = '{0, 3'd2, 8'h22, 264};  wv[4] = '{0, 3'd3, 8'h33, 264};
    wv[5] = '{0, 3'd4, 8'h44, 264};  wv[6] = '{0, 3'd5, 8'h55, 264};
    wv[7] = '{0, 3'd6, 8'h66, 264};  wv[8] = '{0, 3'd7, 8'h77, 264};
    wv[9]  = '{1, 3'd0, 8'h00, 132}; wv[10] = '{1, 3'd1, 8'h11, 132};
    wv[11] = '{1, 3'd2, 8'h22, 132}; wv[12] = '{1, 3'd3, 8'h33, 132};
    wv[13] = '{1, 3'd4, 8'h44, 132}; wv[14] = '{1, 3'd5, 8'h55, 132};
    wv[15] = '{1, 3'd6, 8'h66, 132}; wv[16] = '{1, 3'd7, 8'h77, 132};

    rst_n     = 1'b0;
    wr_req_v  = 2'b00;
    rd_req_v  = 2'b00;
    wr_addr_v = '0;
    wr_data_v = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_cs_n", 64'(cs_n_v[d]), 64'd1);
      chk("reset_sclk", 64'(sclk_v[d]), 64'd0);
      chk("reset_mosi", 64'(mosi_v[d]), 64'd0);
      chk("reset_busy", 64'(busy_v[d]), 64'd0);
      chk("reset_acks", 64'({wr_ack_v[d], rd_ack_v[d], rd_valid_v[d]}), 64'd0);
      chk("reset_rd_data", rd_data_v[d], 64'd0);
    end
    rst_n = 1'b1;

    // Both requesters from reset, then held: grants must alternate W,R,W,R.
    @(negedge clk);
    wr_addr_v[0] = 3'd7;
    wr_data_v[0] = 8'h3C;
    wr_req_v[0]  = 1'b1;
    rd_req_v[0]  = 1'b1;
    ng = 0;
    for (int i = 0; i < 6000 && ng < 4; i++) begin
      @(negedge clk);
      if (wr_ack_v[0]) begin gk[ng] = 1'b0; gt[ng] = cyc; ng++; end
      if (rd_ack_v[0] && ng < 4) begin gk[ng] = 1'b1; gt[ng] = cyc; ng++; end
    end
    wr_req_v[0] = 1'b0;
    rd_req_v[0] = 1'b0;
    chk("rr_grant_count", 64'(ng), 64'd4);
    chk("rr_order", 64'({gk[0], gk[1], gk[2], gk[3]}), 64'b0101);
    chk("rr_spacing_w_r", 64'(gt[1] - gt[0]), 64'd273);
    chk("rr_spacing_r_w", 64'(gt[2] - gt[1]), 64'd785);
    wait_idle(0);

    // Back-to-back writes with wr_req held throughout.
    @(negedge clk);
    wr_addr_v[0] = 3'd1;
    wr_data_v[0] = 8'h5A;
    wr_req_v[0]  = 1'b1;
    ng = 0;
    for (int i = 0; i < 3000 && ng < 2; i++) begin
      @(negedge clk);
      if (wr_ack_v[0]) begin
        gt[ng] = cyc;
        ng++;
        wr_addr_v[0] = 3'd2;
        wr_data_v[0] = 8'h6B;
      end
    end
    wr_req_v[0] = 1'b0;
    chk("b2b_ack_count", 64'(ng), 64'd2);
    chk("b2b_ack_spacing", 64'(gt[1] - gt[0]), 64'd273);
    wait_idle(0);
    chk("b2b_cs_gap_min", 64'(get_hi_len(0) >= 8), 64'd1);
    chk("b2b_reg1", 64'(get_reg(0, 3'd1)), 64'h5A);
    chk("b2b_reg2", 64'(get_reg(0, 3'd2)), 64'h6B);

    // Table of single writes on both instances.
    for (int k = 0; k < 17; k++) begin
      do_write(wv[k].d, wv[k].addr, wv[k].data);
      chk("wr_mosi_bytes", 64'(get_rx(wv[k].d)), 64'({8'h7E, 8'h7E, 5'd0, wv[k].addr, wv[k].data}));
      chk("wr_cs_low_len", 64'(get_cs_len(wv[k].d)), 64'(wv[k].exp_cs));
      chk("wr_slave_reg", 64'(get_reg(wv[k].d, wv[k].addr)), 64'(wv[k].data));
    end

    // Readbacks on both instances.
    do_read(0, rdat, nval);
    chk("rd0_data", rdat, 64'h7766554433221100);
    chk("rd0_cs_low_len", 64'(get_cs_len(0)), 64'd776);
    chk("rd0_mosi_hdr", 64'(get_rx(0)), 64'h7E7E8800);
    chk("rd0_valid_pulses", 64'(nval), 64'd1);
    do_read(1, rdat, nval);
    chk("rd1_data", rdat, 64'h7766554433221100);
    chk("rd1_cs_low_len", 64'(get_cs_len(1)), 64'd388);
    chk("rd1_valid_pulses", 64'(nval), 64'd1);
    do_write(1, 3'd5, 8'hEE);
    chk("rd1_data_held_after_write", rd_data_v[1], 64'h7766554433221100);

    // Reset in the middle of byte 6 of a readback.
    v_before = get_vcnt(0);
    @(negedge clk);
    rd_req_v[0] = 1'b1;
    t_a = 0;
    for (int i = 0; i < 3000 && t_a == 0; i++) begin
      @(negedge clk);
      if (rd_ack_v[0]) t_a = 1;
    end
    rd_req_v[0] = 1'b0;
    chk("mid_rst_ack", 64'(t_a), 64'd1);
    repeat (410) @(negedge clk);
    chk("mid_rst_cs_active", 64'(cs_n_v[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", 64'(cs_n_v[0]), 64'd1);
    chk("mid_rst_sclk", 64'(sclk_v[0]), 64'd0);
    chk("mid_rst_busy", 64'(busy_v[0]), 64'd0);
    chk("mid_rst_rd_data", rd_data_v[0], 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    t_b = get_vcnt(0) - v_before;
    chk("mid_rst_no_valid", 64'(t_b), 64'd0);
    chk("mid_rst_stays_idle", 64'(busy_v[0]), 64'd0);
    do_read(0, rdat, nval);
    chk("post_rst_rd_data", rdat, 64'h7766554433221100);
    chk("post_rst_valid_pulses", 64'(nval), 64'd1);

    chk("sclk_high_while_cs_n_high_0", 64'(g_d[0].sclk_bad), 64'd0);
    chk("sclk_high_while_cs_n_high_1", 64'(g_d[1].sclk_bad), 64'd0);
    chk("sclk_period_0", 64'(g_d[0].per_bad), 64'd0);
    chk("sclk_period_1", 64'(g_d[1].per_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
